// File: rtl/bus_seq_pkg.sv
// bus_seq_pkg: opcodes, FSM state encoding, opcode classes and the strobe
// vector shared by the bus_seq sequencer, its decoder and the bench.
// BUS_SEQ_HALT_EN adds the HALTED state and classifies opcode F as HALT.
package bus_seq_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDA   = 4'h1;
  localparam logic [3:0] OP_LDB   = 4'h2;
  localparam logic [3:0] OP_MOVAB = 4'h3;
  localparam logic [3:0] OP_MOVBA = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_OUTA  = 4'h7;
  localparam logic [3:0] OP_OUTB  = 4'h8;
  localparam logic [3:0] OP_CLRA  = 4'h9;
  localparam logic [3:0] OP_CLRB  = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_DRIVE,
    ST_LATCH,
    ST_DONE
`ifdef BUS_SEQ_HALT_EN
    , ST_HALTED
`endif
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_IMM,
    CL_XFER,
    CL_ILL,
    CL_HALT
  } op_class_t;

  // out_ld is the internal destination strobe for the output latch.
  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rs3;
    logic rs4;
    logic ws1;
    logic ws2;
    logic ws_alu;
    logic alu_sub;
    logic lrst_a;
    logic lrst_b;
    logic out_ld;
  } strobe_t;

  function automatic op_class_t op_class(input logic [3:0] op);
    op_class_t c;
    case (op)
      OP_NOP:                            c = CL_NOP;
      OP_LDA, OP_LDB, OP_CLRA, OP_CLRB:  c = CL_IMM;
      OP_MOVAB, OP_MOVBA, OP_ADD,
      OP_SUB, OP_OUTA, OP_OUTB:          c = CL_XFER;
`ifdef BUS_SEQ_HALT_EN
      OP_HALT:                           c = CL_HALT;
`endif
      default:                           c = CL_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bus_seq_if.sv
// bus_seq_if: instruction handshake, register-file strobes and bus view of
// the bus_seq sequencer. master = sequencer side, slave = environment side.
interface bus_seq_if #(
  parameter int unsigned DW = 4
);
  logic          instr_valid;
  logic          instr_ready;
  logic [7:0]    instr;
  logic [DW-1:0] imm;
  logic          rs1;
  logic          rs2;
  logic          rs3;
  logic          rs4;
  logic          ws1;
  logic          ws2;
  logic          ws_alu;
  logic          alu_sub;
  logic          lrst_a;
  logic          lrst_b;
  logic [DW-1:0] bus;
  logic [DW-1:0] out_q;
  logic          out_vld;
  logic          done;
  logic          illegal;

  modport master (
    input  instr_valid, instr, bus,
    output instr_ready, imm, rs1, rs2, rs3, rs4, ws1, ws2, ws_alu, alu_sub,
           lrst_a, lrst_b, out_q, out_vld, done, illegal
  );

  modport slave (
    output instr_valid, instr, bus,
    input  instr_ready, imm, rs1, rs2, rs3, rs4, ws1, ws2, ws_alu, alu_sub,
           lrst_a, lrst_b, out_q, out_vld, done, illegal
  );
endinterface

// File: rtl/bus_seq_decode.sv
// bus_seq_decode: combinational map from (state, latched opcode) to the
// strobe vector. Sources drive in DRIVE and LATCH, destinations load in
// LATCH only; every other state yields all-zero strobes.
module bus_seq_decode
  import bus_seq_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  output strobe_t    strb
);
  logic src_ph;
  logic dst_ph;

  assign src_ph = (state == ST_DRIVE) || (state == ST_LATCH);
  assign dst_ph = (state == ST_LATCH);

  // Opcode to source/destination strobe selection
  always_comb begin
    strb = '0;
    case (op)
      OP_LDA:   strb.rs1 = dst_ph;
      OP_LDB:   strb.rs3 = dst_ph;
      OP_MOVAB: begin
        strb.ws1 = src_ph;
        strb.rs4 = dst_ph;
      end
      OP_MOVBA: begin
        strb.ws2 = src_ph;
        strb.rs2 = dst_ph;
      end
      OP_ADD: begin
        strb.ws_alu = src_ph;
        strb.rs2    = dst_ph;
      end
      OP_SUB: begin
        strb.ws_alu  = src_ph;
        strb.alu_sub = src_ph;
        strb.rs2     = dst_ph;
      end
      OP_OUTA: begin
        strb.ws1    = src_ph;
        strb.out_ld = dst_ph;
      end
      OP_OUTB: begin
        strb.ws2    = src_ph;
        strb.out_ld = dst_ph;
      end
      OP_CLRA:  strb.lrst_a = dst_ph;
      OP_CLRB:  strb.lrst_b = dst_ph;
      default:  strb = '0;
    endcase
  end
endmodule

// File: rtl/bus_seq.sv
// bus_seq: microcode sequencer and bus initiator for the 4-bit register file.
// Steps one instruction through IDLE/DECODE/DRIVE/LATCH/DONE, emits Moore
// strobes, and captures OUT results from the shared bus into out_q.
// Define BUS_SEQ_HALT_EN to make opcode F a HALT into the HALTED state.
module bus_seq
  import bus_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned DW         = 4
) (
  input logic       clk,
  input logic       grst,
  bus_seq_if.master bif
);
  state_t        state;
  state_t        state_nxt;
  logic [3:0]    op_q;
  logic [2:0]    settle_cnt;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] out_q_q;
  logic          out_vld_q;
  logic          illegal_q;
  logic          accept;
  op_class_t     cls;
  strobe_t       strb;

  assign accept = bif.instr_valid && (state == ST_IDLE);
  assign cls    = op_class(op_q);

  // State register
  always_ff @(posedge clk) begin
    if (grst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_DECODE;
      ST_DECODE: begin
        case (cls)
          CL_IMM:  state_nxt = ST_LATCH;
          CL_XFER: state_nxt = ST_DRIVE;
          default: state_nxt = ST_DONE;
        endcase
      end
      ST_DRIVE:  if (settle_cnt == 3'd1) state_nxt = ST_LATCH;
      ST_LATCH:  state_nxt = ST_DONE;
`ifdef BUS_SEQ_HALT_EN
      ST_DONE:   state_nxt = (op_q == OP_HALT) ? ST_HALTED : ST_IDLE;
      ST_HALTED: state_nxt = ST_HALTED;
`else
      ST_DONE:   state_nxt = ST_IDLE;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Instruction latch, settle counter, output latch and sticky illegal flag
  always_ff @(posedge clk) begin
    if (grst) begin
      op_q       <= '0;
      imm_q      <= '0;
      settle_cnt <= '0;
      out_q_q    <= '0;
      out_vld_q  <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bif.instr[7:4];
        imm_q <= DW'(bif.instr[3:0]);
      end
      if (state == ST_DECODE)     settle_cnt <= 3'(SETTLE_CYC);
      else if (state == ST_DRIVE) settle_cnt <= settle_cnt - 3'd1;
      if ((state == ST_DECODE) && (cls == CL_ILL)) illegal_q <= 1'b1;
      // Capture on the LATCH-exit edge so out_q and out_vld appear in DONE.
      out_vld_q <= strb.out_ld;
      if (strb.out_ld) out_q_q <= bif.bus;
    end
  end

  bus_seq_decode u_decode (
    .state (state),
    .op    (op_q),
    .strb  (strb)
  );

  assign bif.instr_ready = (state == ST_IDLE);
  assign bif.imm         = imm_q;
  assign bif.rs1         = strb.rs1;
  assign bif.rs2         = strb.rs2;
  assign bif.rs3         = strb.rs3;
  assign bif.rs4         = strb.rs4;
  assign bif.ws1         = strb.ws1;
  assign bif.ws2         = strb.ws2;
  assign bif.ws_alu      = strb.ws_alu;
  assign bif.alu_sub     = strb.alu_sub;
  assign bif.lrst_a      = strb.lrst_a;
  assign bif.lrst_b      = strb.lrst_b;
  assign bif.out_q       = out_q_q;
  assign bif.out_vld     = out_vld_q;
  assign bif.done        = (state == ST_DONE);
  assign bif.illegal     = illegal_q;
endmodule

// File: tb/tb_bus_seq.sv
// tb_bus_seq: scoreboard bench for bus_seq. Two instances (SETTLE_CYC 1 and 3)
// share one instruction stream; each has an A/B/ALU register stub on its bus.
// Expected per-instruction results are queued at issue and checked on done.
`timescale 1ns/1ps
module tb_bus_seq;
  localparam int unsigned S0 = 1;
  localparam int unsigned S1 = 3;

  // observed strobe bit positions: {rs1,rs2,rs3,rs4,ws1,ws2,ws_alu,alu_sub,lrst_a,lrst_b}
  localparam logic [9:0] M_RS1 = 10'h200, M_RS2 = 10'h100, M_RS3 = 10'h080,
                         M_RS4 = 10'h040, M_WS1 = 10'h020, M_WS2 = 10'h010,
                         M_WSA = 10'h008, M_SUB = 10'h004, M_LRA = 10'h002,
                         M_LRB = 10'h001;

  typedef struct packed {
    logic [7:0] ins;
    logic [3:0] base;
    logic       xfer;
    logic [9:0] src;
    logic [9:0] dst;
    logic       oc;
    logic [3:0] ov;
    logic       ill;
  } rec_t;

  logic       clk = 1'b0;
  logic       grst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] instr = 8'h00;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_seq_if #(.DW(4)) bif0 ();
  bus_seq_if #(.DW(4)) bif1 ();

  bus_seq #(.SETTLE_CYC(S0), .DW(4)) dut0 (.clk(clk), .grst(grst), .bif(bif0));
  bus_seq #(.SETTLE_CYC(S1), .DW(4)) dut1 (.clk(clk), .grst(grst), .bif(bif1));

  logic [9:0] obs   [2];
  logic [3:0] busv  [2];
  logic [3:0] imm_a [2];
  logic [3:0] oq_a  [2];
  logic       rdy_a [2];
  logic       dn_a  [2];
  logic       ov_a  [2];
  logic       il_a  [2];
  logic [3:0] ra    [2];
  logic [3:0] rb    [2];

  assign bif0.instr_valid = valid;
  assign bif1.instr_valid = valid;
  assign bif0.instr = instr;
  assign bif1.instr = instr;
  assign obs[0] = {bif0.rs1, bif0.rs2, bif0.rs3, bif0.rs4, bif0.ws1, bif0.ws2,
                   bif0.ws_alu, bif0.alu_sub, bif0.lrst_a, bif0.lrst_b};
  assign obs[1] = {bif1.rs1, bif1.rs2, bif1.rs3, bif1.rs4, bif1.ws1, bif1.ws2,
                   bif1.ws_alu, bif1.alu_sub, bif1.lrst_a, bif1.lrst_b};
  assign imm_a[0] = bif0.imm;     assign imm_a[1] = bif1.imm;
  assign oq_a[0]  = bif0.out_q;   assign oq_a[1]  = bif1.out_q;
  assign rdy_a[0] = bif0.instr_ready; assign rdy_a[1] = bif1.instr_ready;
  assign dn_a[0]  = bif0.done;    assign dn_a[1]  = bif1.done;
  assign ov_a[0]  = bif0.out_vld; assign ov_a[1]  = bif1.out_vld;
  assign il_a[0]  = bif0.illegal; assign il_a[1]  = bif1.illegal;

  function automatic logic [3:0] bus_val(input logic [9:0] s, input logic [3:0] a, input logic [3:0] b);
    if (s[5]) return a;
    if (s[4]) return b;
    if (s[3]) return s[2] ? (a - b) : (a + b);
    return 4'h0;
  endfunction

  assign busv[0] = bus_val(obs[0], ra[0], rb[0]);
  assign busv[1] = bus_val(obs[1], ra[1], rb[1]);
  assign bif0.bus = busv[0];
  assign bif1.bus = busv[1];

  // Register A/B stubs that react to the strobes like the real blocks
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (grst) begin
        ra[d] <= 4'h0;
        rb[d] <= 4'h0;
      end else begin
        if (obs[d][1])      ra[d] <= 4'h0;
        else if (obs[d][9]) ra[d] <= imm_a[d];
        else if (obs[d][8]) ra[d] <= busv[d];
        if (obs[d][0])      rb[d] <= 4'h0;
        else if (obs[d][7]) rb[d] <= imm_a[d];
        else if (obs[d][6]) rb[d] <= busv[d];
      end
    end
  end

  rec_t q0[$];
  rec_t q1[$];
  bit   act  [2];
  int   acc  [2];
  int   ovc  [2];
  int   cnt  [2][10];
  int   last [2][10];
  int   rs4_total1 = 0;

  task automatic check_done(input int d);
    rec_t       r;
    int         s;
    int         el;
    int         e;
    bit         ok;
    logic [9:0] mism;
    s = (d == 0) ? S0 : S1;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      total++; bad++;
      $display("FAIL unexpected_done dut%0d cyc=%0d got done with empty queue, required none", d, cyc);
      return;
    end
    r = (d == 0) ? q0.pop_front() : q1.pop_front();
    el = int'(r.base) + (r.xfer ? s : 0);
    total++;
    if (cyc - acc[d] != el) begin
      bad++;
      $display("FAIL latency dut%0d ins=%h got=%0d required=%0d", d, r.ins, cyc - acc[d], el);
    end
    ok = 1'b1;
    mism = '0;
    for (int b = 0; b < 10; b++) begin
      e = r.src[b] ? s + 1 : (r.dst[b] ? 1 : 0);
      if (cnt[d][b] != e || (e != 0 && last[d][b] != cyc - 1)) begin
        ok = 1'b0;
        mism[b] = 1'b1;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL strobes dut%0d ins=%h bad_bits=%b src=%b dst=%b required src %0d cycles, dst 1 cycle, both ending before done",
               d, r.ins, mism, r.src, r.dst, s + 1);
    end
    total++;
    if (r.oc) begin
      if (!(ovc[d] == 1 && ov_a[d] && oq_a[d] == r.ov)) begin
        bad++;
        $display("FAIL out_latch dut%0d ins=%h got out_q=%h vld_now=%b vld_cycles=%0d required out_q=%h vld_now=1 vld_cycles=1",
                 d, r.ins, oq_a[d], ov_a[d], ovc[d], r.ov);
      end
    end else if (ovc[d] != 0) begin
      bad++;
      $display("FAIL out_vld_spurious dut%0d ins=%h got vld_cycles=%0d required 0", d, r.ins, ovc[d]);
    end
    total++;
    if (il_a[d] !== r.ill) begin
      bad++;
      $display("FAIL illegal dut%0d ins=%h got=%b required=%b", d, r.ins, il_a[d], r.ill);
    end
  endtask

  // Monitor: accumulate strobes per instruction and score on each done pulse
  always @(negedge clk) begin
    if (obs[1][6]) rs4_total1 = rs4_total1 + 1;
    for (int d = 0; d < 2; d++) begin
      total++;
      assert ($onehot0(obs[d][5:3])) else begin
        bad++;
        $display("FAIL ws_onehot dut%0d cyc=%0d got ws1/ws2/ws_alu=%b required at most one high", d, cyc, obs[d][5:3]);
      end
      if (act[d]) begin
        for (int b = 0; b < 10; b++) begin
          if (obs[d][b]) begin
            cnt[d][b]  = cnt[d][b] + 1;
            last[d][b] = cyc;
          end
        end
        if (ov_a[d]) ovc[d] = ovc[d] + 1;
      end
      if (dn_a[d]) begin
        check_done(d);
        act[d] = 1'b0;
      end
      if (grst) begin
        act[d] = 1'b0;
      end else if (valid && rdy_a[d]) begin
        act[d] = 1'b1;
        acc[d] = cyc;
        ovc[d] = 0;
        for (int b = 0; b < 10; b++) begin
          cnt[d][b]  = 0;
          last[d][b] = -1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", nm, got, req);
    end
  endtask

  task automatic issue(input logic [7:0] ins, input logic [3:0] base, input logic xfer,
                       input logic [9:0] src, input logic [9:0] dst, input logic oc,
                       input logic [3:0] ov, input logic ill, input bit push);
    int   n;
    rec_t r;
    n = 0;
    while (!(rdy_a[0] && rdy_a[1])) begin
      @(posedge clk); #1;
      n++;
      if (n > 60) begin
        total++; bad++;
        $display("FAIL ready_timeout ins=%h got ready=%b%b required 11", ins, rdy_a[0], rdy_a[1]);
        return;
      end
    end
    r = '{ins: ins, base: base, xfer: xfer, src: src, dst: dst, oc: oc, ov: ov, ill: ill};
    if (push) begin
      q0.push_back(r);
      q1.push_back(r);
    end
    instr = ins;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q0.size() != 0 || q1.size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        total++; bad++;
        $display("FAIL drain_timeout got pending=%0d/%0d required 0/0", q0.size(), q1.size());
        q0.delete();
        q1.delete();
        return;
      end
    end
  endtask

  task automatic check_idle_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ready"},   {7'd0, rdy_a[d]}, 8'h01);
      chk({tag, "_strobes"}, {6'd0, obs[d][9:8]} | {6'd0, obs[d][7:6]} | {2'd0, obs[d][5:0]}, 8'h00);
      chk({tag, "_illegal"}, {7'd0, il_a[d]}, 8'h00);
      chk({tag, "_out_q"},   {4'd0, oq_a[d]}, 8'h00);
      chk({tag, "_imm"},     {4'd0, imm_a[d]}, 8'h00);
      chk({tag, "_done"},    {6'd0, dn_a[d], ov_a[d]}, 8'h00);
    end
  endtask

  initial begin
    int snap;
    int nrdy;
    repeat (3) @(posedge clk);
    #1 grst = 1'b0;
    check_idle_reset("reset");

    //     ins    base xfer src            dst    oc ov    ill
    issue(8'h00, 4'd2, 0, '0,            '0,    0, 4'h0, 0, 1); // NOP
    issue(8'h15, 4'd3, 0, '0,            M_RS1, 0, 4'h0, 0, 1); // LDA 5
    issue(8'h70, 4'd3, 1, M_WS1,         '0,    1, 4'h5, 0, 1); // OUTA -> 5
    issue(8'h23, 4'd3, 0, '0,            M_RS3, 0, 4'h0, 0, 1); // LDB 3
    issue(8'h50, 4'd3, 1, M_WSA,         M_RS2, 0, 4'h0, 0, 1); // ADD A=8
    issue(8'h70, 4'd3, 1, M_WS1,         '0,    1, 4'h8, 0, 1); // OUTA -> 8
    issue(8'h60, 4'd3, 1, M_WSA | M_SUB, M_RS2, 0, 4'h0, 0, 1); // SUB A=5
    issue(8'h30, 4'd3, 1, M_WS1,         M_RS4, 0, 4'h0, 0, 1); // MOVAB B=5
    issue(8'h80, 4'd3, 1, M_WS2,         '0,    1, 4'h5, 0, 1); // OUTB -> 5
    issue(8'h1E, 4'd3, 0, '0,            M_RS1, 0, 4'h0, 0, 1); // LDA E
    issue(8'h29, 4'd3, 0, '0,            M_RS3, 0, 4'h0, 0, 1); // LDB 9
    issue(8'h40, 4'd3, 1, M_WS2,         M_RS2, 0, 4'h0, 0, 1); // MOVBA A=9
    issue(8'h70, 4'd3, 1, M_WS1,         '0,    1, 4'h9, 0, 1); // OUTA -> 9
    issue(8'h97, 4'd3, 0, '0,            M_LRA, 0, 4'h0, 0, 1); // CLRA
    issue(8'h70, 4'd3, 1, M_WS1,         '0,    1, 4'h0, 0, 1); // OUTA -> 0
    issue(8'h12, 4'd3, 0, '0,            M_RS1, 0, 4'h0, 0, 1); // LDA 2
    issue(8'h27, 4'd3, 0, '0,            M_RS3, 0, 4'h0, 0, 1); // LDB 7
    issue(8'h60, 4'd3, 1, M_WSA | M_SUB, M_RS2, 0, 4'h0, 0, 1); // SUB 2-7=B
    issue(8'h70, 4'd3, 1, M_WS1,         '0,    1, 4'hB, 0, 1); // OUTA -> B
    issue(8'h2F, 4'd3, 0, '0,            M_RS3, 0, 4'h0, 0, 1); // LDB F
    issue(8'h50, 4'd3, 1, M_WSA,         M_RS2, 0, 4'h0, 0, 1); // ADD B+F=A
    issue(8'h70, 4'd3, 1, M_WS1,         '0,    1, 4'hA, 0, 1); // OUTA -> A
    issue(8'hA3, 4'd3, 0, '0,            M_LRB, 0, 4'h0, 0, 1); // CLRB
    issue(8'h80, 4'd3, 1, M_WS2,         '0,    1, 4'h0, 0, 1); // OUTB -> 0
    issue(8'hC5, 4'd2, 0, '0,            '0,    0, 4'h0, 1, 1); // undefined
    issue(8'h24, 4'd3, 0, '0,            M_RS3, 0, 4'h0, 1, 1); // LDB 4, illegal sticky
    issue(8'h7D, 4'd3, 1, M_WS1,         '0,    1, 4'hA, 1, 1); // OUTA -> A
    drain();

    // Reset in the second DRIVE cycle of MOVAB on the SETTLE_CYC=3 instance
    snap = rs4_total1;
    issue(8'h36, 4'd3, 1, M_WS1, M_RS4, 0, 4'h0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_drive_ws1", {7'd0, bif1.ws1}, 8'h01);
    grst = 1'b1;
    @(posedge clk); #1;
    grst = 1'b0;
    chk("post_reset_ws1", {7'd0, bif1.ws1}, 8'h00);
    check_idle_reset("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    chk("rs4_never", 8'(rs4_total1 - snap), 8'h00);
    chk("idle_after_reset", {7'd0, rdy_a[1]}, 8'h01);

`ifdef BUS_SEQ_HALT_EN
    issue(8'hF0, 4'd2, 0, '0, '0, 0, 4'h0, 0, 1);
    drain();
    instr = 8'h15;
    valid = 1'b1;
    nrdy = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rdy_a[0] || rdy_a[1] || dn_a[0] || dn_a[1] || obs[0] != '0 || obs[1] != '0) nrdy++;
    end
    chk("halted_quiet_cycles", 8'(nrdy), 8'h00);
    valid = 1'b0;
    grst = 1'b1;
    @(posedge clk); #1;
    grst = 1'b0;
    chk("halt_exit_ready0", {7'd0, rdy_a[0]}, 8'h01);
    chk("halt_exit_ready1", {7'd0, rdy_a[1]}, 8'h01);
`else
    issue(8'hF0, 4'd2, 0, '0, '0, 0, 4'h0, 1, 1);
    issue(8'h00, 4'd2, 0, '0, '0, 0, 4'h0, 1, 1);
    drain();
    @(posedge clk); #1;
    chk("f_ready0", {7'd0, rdy_a[0]}, 8'h01);
    chk("f_ready1", {7'd0, rdy_a[1]}, 8'h01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
